// File: rtl/reservation_station.sv
// reservation_station: out-of-order issue buffer with CDB snooping.
// Holds up to DEPTH dispatched instructions. Operands that are ROB references
// get replaced by CDB broadcasts. The oldest instruction with both operands
// ready is issued through a registered valid/ready output stage.
// Optional feature macro: RS_WAKEUP_BYPASS_EN. When it is defined, an operand
// matched by the CDB in the current cycle counts as ready for select, and its
// value is forwarded straight into the output register.
// Ports:
//   clk, rst (async active-high), flush (sync clear)
//   in_valid/in_ready, in_op, in_rob_id, in_is_ref_1/2, in_data_1/2 : dispatch
//   cdb_valid, cdb_rob_id, cdb_data                                : result bus
//   out_valid/out_ready, out_op, out_rob_id, out_data_1/2          : issue
//   count : number of occupied entries (the output register is not counted)
module reservation_station #(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned ROB_ADDR_WIDTH = 4,
   parameter int unsigned OP_WIDTH       = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [OP_WIDTH-1:0]       in_op,
   input  logic [ROB_ADDR_WIDTH-1:0] in_rob_id,
   input  logic                      in_is_ref_1,
   input  logic                      in_is_ref_2,
   input  logic [31:0]               in_data_1,
   input  logic [31:0]               in_data_2,
   input  logic                      cdb_valid,
   input  logic [ROB_ADDR_WIDTH-1:0] cdb_rob_id,
   input  logic [31:0]               cdb_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OP_WIDTH-1:0]       out_op,
   output logic [ROB_ADDR_WIDTH-1:0] out_rob_id,
   output logic [31:0]               out_data_1,
   output logic [31:0]               out_data_2,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;

   // Entry storage
   logic [DEPTH-1:0]          valid;
   logic [DEPTH-1:0]          rdy1;
   logic [DEPTH-1:0]          rdy2;
   logic [OP_WIDTH-1:0]       e_op  [DEPTH];
   logic [ROB_ADDR_WIDTH-1:0] e_rob [DEPTH];
   logic [ROB_ADDR_WIDTH-1:0] tag1  [DEPTH];
   logic [ROB_ADDR_WIDTH-1:0] tag2  [DEPTH];
   logic [31:0]               val1  [DEPTH];
   logic [31:0]               val2  [DEPTH];
   // older[i][j] = 1 when entry i was inserted before entry j
   logic [DEPTH-1:0]          older [DEPTH];

   logic [DEPTH-1:0] hit1;
   logic [DEPTH-1:0] hit2;
   logic [DEPTH-1:0] cand;
   logic [DEPTH-1:0] win;
   logic             blocked;
   logic             have_win;
   logic [IDX_W-1:0] sel_idx;
   logic [IDX_W-1:0] free_idx;
   logic             cap1;
   logic             cap2;
   logic             do_ins;
   logic             do_issue;

   assign in_ready = (count != CNT_W'(DEPTH));
   assign do_ins   = in_valid && in_ready && !flush;
   assign do_issue = (!out_valid || out_ready) && have_win;

   // Same-cycle capture of a referenced operand being broadcast during dispatch
   assign cap1 = in_is_ref_1 && cdb_valid && (in_data_1[ROB_ADDR_WIDTH-1:0] == cdb_rob_id);
   assign cap2 = in_is_ref_2 && cdb_valid && (in_data_2[ROB_ADDR_WIDTH-1:0] == cdb_rob_id);

   // CDB tag match per waiting operand
   always_comb begin
      hit1 = '0;
      hit2 = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         hit1[i] = valid[i] && !rdy1[i] && cdb_valid && (tag1[i] == cdb_rob_id);
         hit2[i] = valid[i] && !rdy2[i] && cdb_valid && (tag2[i] == cdb_rob_id);
      end
   end

`ifdef RS_WAKEUP_BYPASS_EN
   assign cand = valid & (rdy1 | hit1) & (rdy2 | hit2);
`else
   assign cand = valid & rdy1 & rdy2;
`endif

   // Oldest-ready select: a candidate wins when no older candidate exists
   always_comb begin
      win     = '0;
      blocked = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         blocked = 1'b0;
         for (int j = 0; j < int'(DEPTH); j++) begin
            if (cand[j] && older[j][i]) blocked = 1'b1;
         end
         win[i] = cand[i] && !blocked;
      end
   end

   // Encode the one-hot winner and the lowest free slot
   always_comb begin
      have_win = |win;
      sel_idx  = '0;
      free_idx = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (win[i]) sel_idx = IDX_W'(i);
      end
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (!valid[i]) free_idx = IDX_W'(i);
      end
   end

   // Entry, age matrix, count and output register update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid      <= '0;
         rdy1       <= '0;
         rdy2       <= '0;
         count      <= '0;
         out_valid  <= 1'b0;
         out_op     <= '0;
         out_rob_id <= '0;
         out_data_1 <= '0;
         out_data_2 <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            e_op[i]  <= '0;
            e_rob[i] <= '0;
            tag1[i]  <= '0;
            tag2[i]  <= '0;
            val1[i]  <= '0;
            val2[i]  <= '0;
            older[i] <= '0;
         end
      end else if (flush) begin
         valid     <= '0;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (hit1[i]) begin
               rdy1[i] <= 1'b1;
               val1[i] <= cdb_data;
            end
            if (hit2[i]) begin
               rdy2[i] <= 1'b1;
               val2[i] <= cdb_data;
            end
         end

         // hit* is only set for a non-ready operand, so in the base build the
         // stored value is always chosen here.
         if (do_issue) begin
            valid[sel_idx] <= 1'b0;
            out_valid      <= 1'b1;
            out_op         <= e_op[sel_idx];
            out_rob_id     <= e_rob[sel_idx];
            out_data_1     <= hit1[sel_idx] ? cdb_data : val1[sel_idx];
            out_data_2     <= hit2[sel_idx] ? cdb_data : val2[sel_idx];
         end else if (!out_valid || out_ready) begin
            out_valid <= 1'b0;
         end

         if (do_ins) begin
            valid[free_idx] <= 1'b1;
            e_op[free_idx]  <= in_op;
            e_rob[free_idx] <= in_rob_id;
            tag1[free_idx]  <= in_data_1[ROB_ADDR_WIDTH-1:0];
            tag2[free_idx]  <= in_data_2[ROB_ADDR_WIDTH-1:0];
            rdy1[free_idx]  <= !in_is_ref_1 || cap1;
            rdy2[free_idx]  <= !in_is_ref_2 || cap2;
            val1[free_idx]  <= cap1 ? cdb_data : in_data_1;
            val2[free_idx]  <= cap2 ? cdb_data : in_data_2;
            // New entry is younger than every currently valid entry
            for (int j = 0; j < int'(DEPTH); j++) begin
               older[free_idx][j] <= 1'b0;
               older[j][free_idx] <= valid[j];
            end
         end

         count <= count + CNT_W'(do_ins) - CNT_W'(do_issue);
      end
   end

endmodule
